// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: next-PC, forwarding,
// branch select and controller state.
package pipeline_pkg;

  localparam int unsigned FLUSH_CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    PC_NEXT = 2'b00,
    PC_BRA  = 2'b01,
    PC_JR   = 2'b10,
    PC_JMP  = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_EX  = 2'b01,
    FWD_WB  = 2'b10
  } fwd_t;

  typedef enum logic [1:0] {
    BS_NONE = 2'b00,
    BS_COND = 2'b01,
    BS_JR   = 2'b10,
    BS_JMP  = 2'b11
  } bs_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  // Conditional branches take when the zero flag disagrees with the polarity bit.
  function automatic logic branch_taken(input logic [1:0] bs, input logic ps,
                                        input logic zero);
    logic taken;
    taken = 1'b0;
    case (bs)
      BS_COND:        taken = zero ^ ps;
      BS_JR, BS_JMP:  taken = 1'b1;
      default:        taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
);

  logic [REG_ADDR_WIDTH-1:0] id_RA;
  logic [REG_ADDR_WIDTH-1:0] id_RB;
  logic                      id_use_A;
  logic                      id_use_B;
  logic                      id_RW;
  logic [REG_ADDR_WIDTH-1:0] id_DA;
  logic [1:0]                id_BS;
  logic                      id_PS;
  logic                      ex_zero;
  logic                      mem_busy;

  logic                      hold_all;
  logic                      flush_if;
  logic                      bubble_ex;
  logic [1:0]                pc_sel;
  logic [1:0]                fwd_a_sel;
  logic [1:0]                fwd_b_sel;
  logic [CNT_WIDTH-1:0]      flush_count;
  logic [CNT_WIDTH-1:0]      stall_count;

  modport master (
    output id_RA, id_RB, id_use_A, id_use_B, id_RW, id_DA, id_BS, id_PS,
           ex_zero, mem_busy,
    input  hold_all, flush_if, bubble_ex, pc_sel, fwd_a_sel, fwd_b_sel,
           flush_count, stall_count
  );

  modport slave (
    input  id_RA, id_RB, id_use_A, id_use_B, id_RW, id_DA, id_BS, id_PS,
           ex_zero, mem_busy,
    output hold_all, flush_if, bubble_ex, pc_sel, fwd_a_sel, fwd_b_sel,
           flush_count, stall_count
  );

endinterface

// File: rtl/forward_select.sv
// Operand-forwarding comparator for one EX-stage source mux.
module forward_select
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_i,
  input  logic                      use_i,
  input  logic                      ex_valid_i,
  input  logic                      ex_rw_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_da_i,
  input  logic                      wb_valid_i,
  input  logic                      wb_rw_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_da_i,
  output logic [1:0]                sel_o
);

  logic src_live;

  // R0 is hard-wired, so it is never a forwarding target.
  always_comb begin
    sel_o    = FWD_REG;
    src_live = use_i && (src_i != '0);
    if (src_live && ex_valid_i && ex_rw_i && (ex_da_i == src_i)) begin
      sel_o = FWD_EX;
    end else if (src_live && wb_valid_i && wb_rw_i && (wb_da_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the IF-ID-EX-WB pipeline: forwarding selects,
// branch redirect, flush bubbles and memory-busy hold, with an EX/WB shadow.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  pipeline_hazard_controller_if.slave bus
);

  localparam int unsigned FCW = FLUSH_CNT_WIDTH;

  state_t                    state_q, state_d, saved_q, saved_d, mode;
  logic [FCW-1:0]            fcnt_q, fcnt_d;

  logic                      ex_valid_q, ex_valid_d, ex_rw_q, ex_rw_d, ex_ps_q, ex_ps_d;
  logic [REG_ADDR_WIDTH-1:0] ex_da_q, ex_da_d;
  logic [1:0]                ex_bs_q, ex_bs_d;
  logic                      wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic [REG_ADDR_WIDTH-1:0] wb_da_q, wb_da_d;

  logic [CNT_WIDTH-1:0]      flush_cnt_q, flush_cnt_d, stall_cnt_q, stall_cnt_d;

  logic                      taken_c, hold_c, flush_if_c, bubble_c, redirect_c;
  logic [1:0]                pc_sel_c;

  assign taken_c = ex_valid_q && branch_taken(ex_bs_q, ex_ps_q, bus.ex_zero);

  // HOLD behaves as the state it interrupted the moment mem_busy drops,
  // so the held EX branch is evaluated without losing a cycle.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    fcnt_d     = fcnt_q;
    hold_c     = 1'b0;
    flush_if_c = 1'b0;
    bubble_c   = 1'b0;
    redirect_c = 1'b0;
    pc_sel_c   = PC_NEXT;
    mode       = (state_q == HOLD) ? saved_q : state_q;
    if (bus.mem_busy) begin
      hold_c  = 1'b1;
      state_d = HOLD;
      saved_d = mode;
    end else if (taken_c) begin
      pc_sel_c   = ex_bs_q;
      flush_if_c = 1'b1;
      bubble_c   = 1'b1;
      redirect_c = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d = FLUSH;
        fcnt_d  = FCW'(FLUSH_CYCLES);
      end else begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end else begin
      case (mode)
        FLUSH: begin
          flush_if_c = 1'b1;
          bubble_c   = 1'b1;
          if (fcnt_q <= FCW'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            state_d = FLUSH;
            fcnt_d  = fcnt_q - FCW'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Shadow of the EX/WB stages plus saturating event counters.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rw_d     = ex_rw_q;
    ex_da_d     = ex_da_q;
    ex_bs_d     = ex_bs_q;
    ex_ps_d     = ex_ps_q;
    wb_valid_d  = wb_valid_q;
    wb_rw_d     = wb_rw_q;
    wb_da_d     = wb_da_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold_c) begin
      ex_valid_d = !bubble_c;
      ex_rw_d    = bus.id_RW;
      ex_da_d    = bus.id_DA;
      ex_bs_d    = bus.id_BS;
      ex_ps_d    = bus.id_PS;
      wb_valid_d = ex_valid_q;
      wb_rw_d    = ex_rw_q;
      wb_da_d    = ex_da_q;
    end
    if (redirect_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    if (hold_c && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_rw_q     <= 1'b0;
      ex_da_q     <= '0;
      ex_bs_q     <= '0;
      ex_ps_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rw_q     <= 1'b0;
      wb_da_q     <= '0;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rw_q     <= ex_rw_d;
      ex_da_q     <= ex_da_d;
      ex_bs_q     <= ex_bs_d;
      ex_ps_q     <= ex_ps_d;
      wb_valid_q  <= wb_valid_d;
      wb_rw_q     <= wb_rw_d;
      wb_da_q     <= wb_da_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .src_i      (bus.id_RA),
    .use_i      (bus.id_use_A),
    .ex_valid_i (ex_valid_q),
    .ex_rw_i    (ex_rw_q),
    .ex_da_i    (ex_da_q),
    .wb_valid_i (wb_valid_q),
    .wb_rw_i    (wb_rw_q),
    .wb_da_i    (wb_da_q),
    .sel_o      (bus.fwd_a_sel)
  );

  forward_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .src_i      (bus.id_RB),
    .use_i      (bus.id_use_B),
    .ex_valid_i (ex_valid_q),
    .ex_rw_i    (ex_rw_q),
    .ex_da_i    (ex_da_q),
    .wb_valid_i (wb_valid_q),
    .wb_rw_i    (wb_rw_q),
    .wb_da_i    (wb_da_q),
    .sel_o      (bus.fwd_b_sel)
  );

  assign bus.hold_all    = hold_c;
  assign bus.flush_if    = flush_if_c;
  assign bus.bubble_ex   = bubble_c;
  assign bus.pc_sel      = pc_sel_c;
  assign bus.flush_count = flush_cnt_q;
  assign bus.stall_count = stall_cnt_q;

endmodule
